// File: rtl/axis_type.svh
// axis_type: AXI-Stream beat and handshake types; included inside a module that defines DATA_WIDTH, ID_WIDTH, DEST_WIDTH, USER_WIDTH
typedef struct packed {
  logic [DATA_WIDTH-1:0] tdata;
  logic [ID_WIDTH-1:0]   tid;
  logic [DEST_WIDTH-1:0] tdest;
  logic [USER_WIDTH-1:0] tuser;
  logic                  tlast;
} axis_data_t;

typedef struct packed {
  axis_data_t data;
  logic       tvalid;
} axis_mosi_t;

typedef struct packed {
  logic tready;
} axis_miso_t;

// File: rtl/axis_channel_arbiter.sv
// axis_channel_arbiter: packet-atomic round-robin merge of CHANNEL_NUMBER AXI-Stream channels into one registered output
//   clk_i/rst_i : clock, synchronous active-high reset
//   in_mosi_i   : per-channel axis_mosi_t (data incl. TLAST, TVALID), packed flat
//   in_miso_o   : per-channel axis_miso_t (TREADY)
//   out_mosi_o  : merged axis_mosi_t from the single output register slot
//   out_miso_i  : merged axis_miso_t (TREADY)
//   grant_o     : channel index owning the beat in the output slot
module axis_channel_arbiter #(
  parameter int CHANNEL_NUMBER = 8,
  parameter int DATA_WIDTH     = 32,
  parameter int ID_WIDTH       = 4,
  parameter int DEST_WIDTH     = 4,
  parameter int USER_WIDTH     = 4
) (
  input  logic                                                                     clk_i,
  input  logic                                                                     rst_i,
  input  logic [CHANNEL_NUMBER-1:0][DATA_WIDTH+ID_WIDTH+DEST_WIDTH+USER_WIDTH+1:0] in_mosi_i,
  output logic [CHANNEL_NUMBER-1:0]                                                in_miso_o,
  output logic [DATA_WIDTH+ID_WIDTH+DEST_WIDTH+USER_WIDTH+1:0]                     out_mosi_o,
  input  logic                                                                     out_miso_i,
  output logic [$clog2(CHANNEL_NUMBER)-1:0]                                        grant_o
);
  `include "axis_type.svh"

  localparam int GW = $clog2(CHANNEL_NUMBER);

  typedef enum logic {IDLE, LOCKED} state_t;

  axis_mosi_t [CHANNEL_NUMBER-1:0] w_in;
  axis_miso_t [CHANNEL_NUMBER-1:0] w_in_rdy;
  axis_miso_t                      w_out_rdy;
  axis_mosi_t                      r_out;
  state_t                          r_state, w_state;
  logic [GW-1:0]                   r_ptr, w_ptr, r_lck, w_lck, r_grant, w_cand, w_sel;
  logic                            w_found, w_req, w_free, w_take;

  function automatic logic [GW-1:0] wrap(input int v);
    return GW'(v % CHANNEL_NUMBER);
  endfunction

  assign w_in       = in_mosi_i;
  assign in_miso_o  = w_in_rdy;
  assign w_out_rdy  = out_miso_i;
  assign out_mosi_o = r_out;
  assign grant_o    = r_grant;

  // Descending scan so the valid channel closest to ptr (ptr itself first) wins.
  always_comb begin
    w_cand  = r_ptr;
    w_found = 1'b0;
    for (int k = CHANNEL_NUMBER - 1; k >= 0; k--)
      if (w_in[wrap(int'(r_ptr) + k)].tvalid) begin
        w_cand  = wrap(int'(r_ptr) + k);
        w_found = 1'b1;
      end
  end

  assign w_free = !r_out.tvalid || w_out_rdy.tready;
  assign w_sel  = r_state == LOCKED ? r_lck : w_cand;
  assign w_req  = r_state == LOCKED ? w_in[r_lck].tvalid : w_found;
  // Accept is combinational on downstream TREADY so a full slot can hand over and reload in the same cycle.
  assign w_take = !rst_i && w_req && w_free;

  always_comb begin
    w_in_rdy               = '0;
    w_in_rdy[w_sel].tready = w_take;
    w_state                = r_state;
    w_ptr                  = r_ptr;
    w_lck                  = r_lck;
    if (w_take) begin
      w_state = w_in[w_sel].data.tlast ? IDLE : LOCKED;
      w_lck   = w_in[w_sel].data.tlast ? r_lck : w_sel;
      w_ptr   = w_in[w_sel].data.tlast ? wrap(int'(w_sel) + 1) : r_ptr;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state <= IDLE;
      r_ptr   <= '0;
      r_lck   <= '0;
      r_out   <= '0;
      r_grant <= '0;
    end else begin
      r_state <= w_state;
      r_ptr   <= w_ptr;
      r_lck   <= w_lck;
      if (w_take) begin
        r_out   <= w_in[w_sel];
        r_grant <= w_sel;
      end else if (w_out_rdy.tready) begin
        r_out.tvalid <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_axis_channel_arbiter.sv
// tb_axis_channel_arbiter: scoreboard bench for the packet-atomic round-robin stream arbiter
module tb_axis_channel_arbiter;
  localparam int N          = 8;
  localparam int DATA_WIDTH = 32;
  localparam int ID_WIDTH   = 4;
  localparam int DEST_WIDTH = 4;
  localparam int USER_WIDTH = 4;

  `include "axis_type.svh"

  typedef struct packed {
    logic [2:0] g;
    axis_data_t d;
  } exp_t;

  logic                 clk, rst, out_rdy, sb_off;
  axis_mosi_t [N-1:0]   in_mosi;
  logic [N-1:0]         in_miso, hs;
  axis_mosi_t           out_mosi;
  logic [2:0]           grant;
  axis_data_t           src_q[N][$];
  int                   gap_q[N][$];
  exp_t                 exp_q[$];
  int                   out_cyc_q[$];
  int                   cyc, n_vec, n_err;

  axis_channel_arbiter #(
    .CHANNEL_NUMBER(N), .DATA_WIDTH(DATA_WIDTH), .ID_WIDTH(ID_WIDTH),
    .DEST_WIDTH(DEST_WIDTH), .USER_WIDTH(USER_WIDTH)
  ) dut (
    .clk_i(clk), .rst_i(rst), .in_mosi_i(in_mosi), .in_miso_o(in_miso),
    .out_mosi_o(out_mosi), .out_miso_i(out_rdy), .grant_o(grant)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic axis_data_t mk(input int ch, input int v, input bit last);
    axis_data_t d;
    d.tdata = 32'(v);
    d.tid   = 4'(ch);
    d.tdest = 4'(ch + 3);
    d.tuser = 4'(v);
    d.tlast = last;
    return d;
  endfunction

  task automatic send(input int ch, input int v, input bit last, input int gap);
    src_q[ch].push_back(mk(ch, v, last));
    gap_q[ch].push_back(gap);
  endtask

  task automatic exp_beat(input int ch, input int v, input bit last);
    exp_t e;
    e.g = 3'(ch);
    e.d = mk(ch, v, last);
    exp_q.push_back(e);
  endtask

  function automatic int pending();
    int p = exp_q.size();
    for (int i = 0; i < N; i++) p += src_q[i].size();
    return p;
  endfunction

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic wait_done(input int budget);
    int n = 0;
    while (pending() > 0 && n < budget) begin
      @(posedge clk);
      n++;
    end
    #2;
    check("drain", 64'(pending()), 64'(0));
  endtask

  // Channel sources: pop on the handshake seen before this edge, then present the next beat after its gap.
  always @(posedge clk) begin
    #1;
    for (int i = 0; i < N; i++) begin
      if (hs[i] && src_q[i].size() > 0) begin
        void'(src_q[i].pop_front());
        void'(gap_q[i].pop_front());
      end
      in_mosi[i].tvalid = 1'b0;
      in_mosi[i].data   = '0;
      if (src_q[i].size() > 0) begin
        if (gap_q[i][0] > 0) gap_q[i][0] = gap_q[i][0] - 1;
        else begin
          in_mosi[i].data   = src_q[i][0];
          in_mosi[i].tvalid = 1'b1;
        end
      end
    end
  end

  always @(negedge clk) begin
    cyc++;
    for (int i = 0; i < N; i++) hs[i] = in_mosi[i].tvalid && in_miso[i];
    check("rdy_onehot", 64'($countones(in_miso) > 1), 64'(0));
    if (out_mosi.tvalid && out_rdy && !sb_off) begin
      out_cyc_q.push_back(cyc);
      check("beat", 64'({grant, out_mosi.data}), exp_q.size() > 0 ? 64'(exp_q.pop_front()) : '1);
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    n_vec = 0; n_err = 0; cyc = 0; hs = '0;
    rst = 1'b1; out_rdy = 1'b1; sb_off = 1'b0;
    for (int p = 1; p <= 2; p++)
      for (int c = 0; c < N; c++) begin
        send(c, 'h100 * p + c, 1'b1, 0);
        exp_beat(c, 'h100 * p + c, 1'b1);
      end
    tick();
    tick();
    @(negedge clk);
    check("rst_rdy", 64'(in_miso), 64'(0));
    check("rst_out", 64'(out_mosi), 64'(0));
    check("rst_grant", 64'(grant), 64'(0));
    tick();
    rst = 1'b0;
    out_cyc_q.delete();
    wait_done(200);
    check("rr_count", 64'(out_cyc_q.size()), 64'(16));
    check("rr_span", 64'(out_cyc_q.size() == 16 ? out_cyc_q[15] - out_cyc_q[0] : -1), 64'(15));

    send(6, 'h300, 1'b1, 0); exp_beat(6, 'h300, 1'b1);
    wait_done(50);
    send(7, 'h301, 1'b1, 0); send(0, 'h302, 1'b1, 0);
    exp_beat(7, 'h301, 1'b1); exp_beat(0, 'h302, 1'b1);
    wait_done(50);

    for (int b = 0; b < 4; b++) begin
      send(2, 'hA0 + b, b == 3, 0);
      exp_beat(2, 'hA0 + b, b == 3);
    end
    send(5, 'h500, 1'b1, 0); exp_beat(5, 'h500, 1'b1);
    wait_done(50);

    send(2, 'hB0, 1'b0, 0); send(2, 'hB1, 1'b0, 3); send(2, 'hB2, 1'b1, 0);
    send(3, 'h600, 1'b1, 0);
    exp_beat(2, 'hB0, 1'b0); exp_beat(2, 'hB1, 1'b0); exp_beat(2, 'hB2, 1'b1);
    exp_beat(3, 'h600, 1'b1);
    out_cyc_q.delete();
    wait_done(50);
    check("gap_count", 64'(out_cyc_q.size()), 64'(4));
    check("gap_bubble", 64'(out_cyc_q.size() == 4 ? out_cyc_q[1] - out_cyc_q[0] : -1), 64'(4));
    check("gap_resume", 64'(out_cyc_q.size() == 4 ? out_cyc_q[3] - out_cyc_q[1] : -1), 64'(2));

    out_rdy = 1'b0;
    send(0, 'h55, 1'b1, 0); send(1, 'h66, 1'b1, 0);
    exp_beat(0, 'h55, 1'b1); exp_beat(1, 'h66, 1'b1);
    tick();
    tick();
    for (int s = 0; s < 5; s++) begin
      @(negedge clk);
      check("stall_data", 64'(out_mosi.data.tdata), 64'('h55));
      check("stall_vld", 64'(out_mosi.tvalid), 64'(1));
      check("stall_rdy", 64'(in_miso), 64'(0));
      tick();
    end
    out_rdy = 1'b1;
    wait_done(50);

    send(4, 'h700, 1'b1, 0); exp_beat(4, 'h700, 1'b1);
    wait_done(50);
    sb_off = 1'b1;
    for (int b = 0; b < 4; b++) send(4, 'h710 + b, b == 3, 0);
    tick();
    tick();
    tick();
    rst = 1'b1;
    for (int i = 0; i < N; i++) begin
      src_q[i].delete();
      gap_q[i].delete();
    end
    @(negedge clk);
    check("rst2_rdy", 64'(in_miso), 64'(0));
    tick();
    rst = 1'b0;
    sb_off = 1'b0;
    @(negedge clk);
    check("rst2_vld", 64'(out_mosi.tvalid), 64'(0));
    check("rst2_grant", 64'(grant), 64'(0));
    tick();
    send(1, 'h801, 1'b1, 0); send(7, 'h807, 1'b1, 0);
    exp_beat(1, 'h801, 1'b1); exp_beat(7, 'h807, 1'b1);
    wait_done(50);
    tick();
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/axis_channel_arbiter.md
AXIS_CHANNEL_ARBITER -- requirements
Module: axis_channel_arbiter

Interface
REQ-001 SHALL have parameter CHANNEL_NUMBER, default 8: number of input stream channels (2..16).
REQ-002 SHALL have parameter DATA_WIDTH, default 32: TDATA width inside axis_data_t.
REQ-003 SHALL have parameter ID_WIDTH, default 4: TID width inside axis_data_t.
REQ-004 SHALL have parameter DEST_WIDTH, default 4: TDEST width inside axis_data_t.
REQ-005 SHALL have parameter USER_WIDTH, default 4: TUSER width inside axis_data_t.
REQ-006 SHALL have port clk_i, input, 1: the single clock; all state changes on its rising edge.
REQ-007 SHALL have port rst_i, input, 1: reset, synchronous and active-high.
REQ-008 SHALL have port in_mosi_i, input, axis_mosi_t[CHANNEL_NUMBER]: per-channel data (incl. TLAST) and TVALID, driven by the per-channel FIFO buffer outputs.
REQ-009 SHALL have port in_miso_o, output, axis_miso_t[CHANNEL_NUMBER]: per-channel TREADY.
REQ-010 SHALL have port out_mosi_o, output, axis_mosi_t: merged stream data and TVALID.
REQ-011 SHALL have port out_miso_i, input, axis_miso_t: merged stream TREADY.
REQ-012 SHALL have port grant_o, output, $clog2(CHANNEL_NUMBER): index of the channel owning the current output beat.
REQ-013 SHALL obtain axis_mosi_t, axis_miso_t and axis_data_t from axis_type.svh.

Function
REQ-014 SHALL merge the input channels into one output stream, packet-atomically: no interleaving of beats from different channels between a first beat and its TLAST beat.
REQ-015 SHALL hold one output register slot (data, TVALID, grant index); slot_free = !out TVALID || out TREADY.
REQ-016 SHALL implement FSM IDLE / LOCKED; pointer ptr (0..CHANNEL_NUMBER-1); locked index lck.
REQ-017 IDLE: candidate = first channel i with TVALID, searching ptr, ptr+1, ..., wrapping modulo CHANNEL_NUMBER; none -> no grant.
REQ-018 IDLE with candidate c and slot_free: assert in TREADY[c] only, load beat into slot, grant_o <= c; if beat TLAST=0 -> LOCKED with lck=c; if TLAST=1 -> stay IDLE, ptr <= (c+1) mod CHANNEL_NUMBER.
REQ-019 LOCKED: assert TREADY only on channel lck and only when slot_free; other channels' TREADY SHALL be 0 regardless of their TVALID.
REQ-020 LOCKED beat accepted with TLAST=1 -> IDLE, ptr <= (lck+1) mod CHANNEL_NUMBER; TLAST=0 -> stay LOCKED.
REQ-021 LOCKED with lck TVALID low -> output slot drains normally, no new load, state held (bubbles allowed, no reselection).
REQ-022 Input TREADY SHALL depend combinationally on out TREADY (zero-bubble throughput: one beat per cycle sustained when out TREADY=1).
REQ-023 Output SHALL be stable while TVALID=1 and TREADY=0 (AXI-Stream rule); slot reloaded only when slot_free.
REQ-024 Latency: beat accepted in cycle N SHALL appear on out_mosi_o in cycle N+1.
REQ-025 Single-beat packets from all channels SHALL be served in strict round-robin order; each requesting channel served at most once per CHANNEL_NUMBER packets.
REQ-026 Data fields (TDATA, TID, TDEST, TUSER, TLAST) SHALL pass unmodified.

Reset
REQ-027 rst_i=1 at a rising edge SHALL set: state IDLE, ptr 0, lck 0, out TVALID 0, out data 0, grant_o 0.
REQ-028 While rst_i=1, all in TREADY SHALL be 0.
REQ-029 Reset mid-packet SHALL discard the slot beat and the lock without error; first cycle after reset behaves as REQ-017 with ptr 0.

Verification
REQ-030 All 8 channels present single-beat TLAST=1 packets, out TREADY=1 -> grant_o sequence 0,1,2,...,7,0 on consecutive cycles, one beat per cycle.
REQ-031 Ch2 sends 4-beat packet (TDATA 0xA0..0xA3), ch5 valid throughout -> output A0,A1,A2,A3 then ch5 beat; ch5 TREADY=0 during all ch2 beats.
REQ-032 Ch2 mid-packet, TVALID drops 3 cycles, ch3 valid -> output gaps of 3 cycles, no ch3 beat until ch2 TLAST.
REQ-033 out TREADY=0 for 5 cycles while slot holds 0x55 -> out_mosi_o held 0x55, all in TREADY=0, no beat lost or duplicated after release.
REQ-034 ptr=7, requests on ch7 and ch0 -> ch7 served, then ch0 (wrap-around).
REQ-035 rst_i pulsed during beat 2 of ch4 packet -> next cycle out TVALID=0, grant_o=0, ptr=0; new request on ch1 granted normally.
